// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the fetch-stage PC unit.
//   npc_op_e  : next-PC operation selected by control
//   br_cond_e : conditional-branch comparison selected by control
//   br_cond_legal : true for the defined branch-condition encodings
package pc_pkg;

    localparam int NPC_OP_W   = 3;
    localparam int BR_COND_W  = 3;
    localparam int DATA_W     = 32;

    typedef enum logic [NPC_OP_W-1:0] {
        NPC_SEQ  = 3'b000,
        NPC_J    = 3'b001,
        NPC_JR   = 3'b010,
        NPC_BR   = 3'b011,
        NPC_ERET = 3'b100
    } npc_op_e;

    typedef enum logic [BR_COND_W-1:0] {
        BR_BEQ  = 3'b000,
        BR_BNE  = 3'b001,
        BR_BLEZ = 3'b010,
        BR_BGTZ = 3'b011,
        BR_BLTZ = 3'b100,
        BR_BGEZ = 3'b101
    } br_cond_e;

    function automatic logic br_cond_legal(input logic [BR_COND_W-1:0] cond);
        return (cond <= BR_BGEZ);
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// br_cond_eval: evaluates the branch condition for a conditional branch.
//   rs_val  in  32  operand A (signed for the compare-with-zero forms)
//   rt_val  in  32  operand B (beq/bne only)
//   cond    in  3   condition code (br_cond_e encoding)
//   take    out 1   condition holds
//   legal   out 1   cond is a defined encoding
module br_cond_eval
    import pc_pkg::*;
(
    input  logic [DATA_W-1:0]    rs_val,
    input  logic [DATA_W-1:0]    rt_val,
    input  logic [BR_COND_W-1:0] cond,
    output logic                 take,
    output logic                 legal
);

    logic rs_zero;
    logic rs_neg;

    // Signed compare against zero only needs the sign bit and a zero test.
    assign rs_zero = (rs_val == '0);
    assign rs_neg  = rs_val[DATA_W-1];
    assign legal   = br_cond_legal(cond);

    always_comb begin
        take = 1'b0;
        case (cond)
            BR_BEQ:  take = (rs_val == rt_val);
            BR_BNE:  take = (rs_val != rt_val);
            BR_BLEZ: take = rs_neg | rs_zero;
            BR_BGTZ: take = !rs_neg && !rs_zero;
            BR_BLTZ: take = rs_neg;
            BR_BGEZ: take = !rs_neg;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit_v2.sv
// pc_unit_v2: fetch-stage PC unit. Holds PC, EPC, the exception-level bit
// and a latched interrupt-pending flag, and registers the next PC each cycle.
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   stall_i      hold PC/EPC/EXL this cycle (interrupt capture continues)
//   npc_op_i     seq / j / jr / cond branch / eret
//   br_cond_i    branch condition; rs_val_i, rt_val_i operands
//   imm16_i      branch word offset; idx26_i jump index; jr_val_i jr target
//   int_req_i    interrupt request pulse; int_en_i global enable
//   exc_req_i    synchronous exception for the instruction at pc_o
//   pc_o, epc_o, exl_o  architectural registers
//   pc_4_o       pc_o + 4
//   taken_o      next PC differs from pc_o + 4 (not stalled)
module pc_unit_v2
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_3000,
    parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0000_4180
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic [NPC_OP_W-1:0]  npc_op_i,
    input  logic [BR_COND_W-1:0] br_cond_i,
    input  logic [DATA_W-1:0]    rs_val_i,
    input  logic [DATA_W-1:0]    rt_val_i,
    input  logic [15:0]          imm16_i,
    input  logic [25:0]          idx26_i,
    input  logic [ADDR_W-1:0]    jr_val_i,
    input  logic                 int_req_i,
    input  logic                 int_en_i,
    input  logic                 exc_req_i,
    output logic [ADDR_W-1:0]    pc_o,
    output logic [ADDR_W-1:0]    pc_4_o,
    output logic [ADDR_W-1:0]    epc_o,
    output logic                 exl_o,
    output logic                 taken_o
);

    localparam logic [ADDR_W-1:0] INSN_BYTES = ADDR_W'(4);

    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] epc_reg, epc_next;
    logic              exl_reg, exl_next;
    logic              int_pend_reg, int_pend_next;

    logic [ADDR_W-1:0] pc_4;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] flow_pc;
    logic              flow_is_eret;
    logic              br_take;
    logic              br_legal;
    logic              int_take;

    br_cond_eval u_br_cond_eval (
        .rs_val (rs_val_i),
        .rt_val (rt_val_i),
        .cond   (br_cond_i),
        .take   (br_take),
        .legal  (br_legal)
    );

    assign pc_4      = pc_reg + INSN_BYTES;
    // Word offset, sign-extended to the PC width; wraps mod 2^ADDR_W.
    assign br_off    = {{(ADDR_W-18){imm16_i[15]}}, imm16_i, 2'b00};
    assign br_target = pc_reg + br_off;

    // Jump keeps the PC bits above the 28-bit region; with a 28-bit PC
    // there are none to keep.
    generate
        if (ADDR_W > 28) begin : g_jmp_hi
            assign j_target = {pc_reg[ADDR_W-1:28], idx26_i, 2'b00};
        end else begin : g_jmp_lo
            assign j_target = {idx26_i, 2'b00};
        end
    endgenerate

    // Normal instruction flow, before exceptions/interrupts are considered.
    always_comb begin
        flow_pc      = RESET_VEC;
        flow_is_eret = 1'b0;
        case (npc_op_i)
            NPC_SEQ:  flow_pc = pc_4;
            NPC_J:    flow_pc = j_target;
            NPC_JR:   flow_pc = jr_val_i;
            NPC_BR: begin
                if (!br_legal) begin
                    flow_pc = RESET_VEC;
                end else if (br_take) begin
                    flow_pc = br_target;
                end else begin
                    flow_pc = pc_4;
                end
            end
            NPC_ERET: begin
                flow_pc      = epc_reg;
                flow_is_eret = 1'b1;
            end
            default:  flow_pc = RESET_VEC;
        endcase
    end

    // Interrupts are masked by IE and by an active exception level.
    assign int_take = int_pend_reg && int_en_i && !exl_reg;

    always_comb begin
        pc_next       = pc_reg;
        epc_next      = epc_reg;
        exl_next      = exl_reg;
        // A new request always lands in the pending flag, even when stalled.
        int_pend_next = int_pend_reg | int_req_i;

        if (!stall_i) begin
            if (exc_req_i) begin
                pc_next = EXC_VEC;
                // A nested exception must not overwrite the outer return PC.
                if (!exl_reg) begin
                    epc_next = pc_reg;
                    exl_next = 1'b1;
                end
            end else if (int_take) begin
                // The instruction at pc_o has not executed; it is re-run on eret.
                pc_next       = EXC_VEC;
                epc_next      = pc_reg;
                exl_next      = 1'b1;
                // A request arriving in the same cycle stays pending.
                int_pend_next = int_req_i;
            end else begin
                pc_next = flow_pc;
                if (flow_is_eret) begin
                    exl_next = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_VEC;
            epc_reg      <= '0;
            exl_reg      <= 1'b0;
            int_pend_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            epc_reg      <= epc_next;
            exl_reg      <= exl_next;
            int_pend_reg <= int_pend_next;
        end
    end

    assign pc_o    = pc_reg;
    assign pc_4_o  = pc_4;
    assign epc_o   = epc_reg;
    assign exl_o   = exl_reg;
    assign taken_o = !stall_i && (pc_next != pc_4);

endmodule

// File: tb/tb_pc_unit_v2.sv
module tb_pc_unit_v2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_i = 1'b0;
    logic [2:0]  npc_op_i = 3'b000;
    logic [2:0]  br_cond_i = 3'b000;
    logic [31:0] rs_val_i = '0;
    logic [31:0] rt_val_i = '0;
    logic [15:0] imm16_i = '0;
    logic [25:0] idx26_i = '0;
    logic [31:0] jr_val_i = '0;
    logic        int_req_i = 1'b0;
    logic        int_en_i = 1'b0;
    logic        exc_req_i = 1'b0;
    logic [31:0] pc_o, pc_4_o, epc_o;
    logic        exl_o, taken_o;

    pc_unit_v2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall_i   (stall_i),
        .npc_op_i  (npc_op_i),
        .br_cond_i (br_cond_i),
        .rs_val_i  (rs_val_i),
        .rt_val_i  (rt_val_i),
        .imm16_i   (imm16_i),
        .idx26_i   (idx26_i),
        .jr_val_i  (jr_val_i),
        .int_req_i (int_req_i),
        .int_en_i  (int_en_i),
        .exc_req_i (exc_req_i),
        .pc_o      (pc_o),
        .pc_4_o    (pc_4_o),
        .epc_o     (epc_o),
        .exl_o     (exl_o),
        .taken_o   (taken_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        exl;
        logic        taken;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string nm, input string fld,
                       input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    // Monitor: the design has no valid strobe, so every driven cycle is a
    // transaction; outputs are sampled 2 time units after the driving edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.nm, "pc",    pc_o,   e.pc);
                chk(e.nm, "pc_4",  pc_4_o, e.pc + 32'd4);
                chk(e.nm, "epc",   epc_o,  e.epc);
                chk(e.nm, "exl",   {31'd0, exl_o},   {31'd0, e.exl});
                chk(e.nm, "taken", {31'd0, taken_o}, {31'd0, e.taken});
                $display("txn %-10s pc=%h epc=%h exl=%0b taken=%0b",
                         e.nm, pc_o, epc_o, exl_o, taken_o);
            end
        end
    end

    // Drive one cycle of inputs and queue the state expected before the
    // following clock edge (current registers + combinational taken).
    task automatic v(input string nm, input logic rst, input logic stl,
                     input logic [2:0] op, input logic [2:0] cnd,
                     input logic [31:0] rs, input logic [31:0] rt,
                     input logic [15:0] imm, input logic [25:0] idx,
                     input logic [31:0] jr, input logic ireq,
                     input logic ien, input logic exc,
                     input logic [31:0] e_pc, input logic [31:0] e_epc,
                     input logic e_exl, input logic e_taken);
        exp_t e;
        @(negedge clk);
        rst_n = !rst;  stall_i = stl;  npc_op_i = op;  br_cond_i = cnd;
        rs_val_i = rs; rt_val_i = rt;  imm16_i = imm;  idx26_i = idx;
        jr_val_i = jr; int_req_i = ireq; int_en_i = ien; exc_req_i = exc;
        e.nm = nm; e.pc = e_pc; e.epc = e_epc; e.exl = e_exl; e.taken = e_taken;
        exp_q.push_back(e);
    endtask

    initial begin
        //  name        rst stl op    cnd   rs            rt     imm       idx        jr            irq ien exc  pc            epc           exl tkn
        v("rst",        1, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3000, 32'h0,        0, 0);
        v("seq0",       0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3000, 32'h0,        0, 0);
        v("seq1",       0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3004, 32'h0,        0, 0);
        v("seq2",       0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3008, 32'h0,        0, 0);
        v("seq3",       0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 0, 0, 32'h0000_300C, 32'h0,        0, 0);
        // pc is 0x3010 here; reset is asserted mid-cycle with no clock edge
        v("rst_mid",    1, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3000, 32'h0,        0, 0);
        v("bne",        0, 0, 3'd3, 3'd1, 32'h1,        32'h2, 16'hFFFF, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3000, 32'h0,        0, 1);
        v("jr_p4",      0, 0, 3'd2, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0000_3000, 0, 0, 0, 32'h0000_2FFC, 32'h0,       0, 0);
        v("bgez_n",     0, 0, 3'd3, 3'd5, 32'h8000_0000, 32'h0, 16'h0010, 26'h0,    32'h0,        0, 0, 0, 32'h0000_3000, 32'h0,        0, 0);
        v("beq",        0, 0, 3'd3, 3'd0, 32'h5,        32'h5, 16'h0004, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3004, 32'h0,        0, 1);
        v("blez0",      0, 0, 3'd3, 3'd2, 32'h0,        32'h0, 16'h0002, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3014, 32'h0,        0, 1);
        v("bgtz0",      0, 0, 3'd3, 3'd3, 32'h0,        32'h0, 16'h0002, 26'h0,     32'h0,        0, 0, 0, 32'h0000_301C, 32'h0,        0, 0);
        v("bltz",       0, 0, 3'd3, 3'd4, 32'hFFFF_FFFF, 32'h0, 16'h0002, 26'h0,    32'h0,        0, 0, 0, 32'h0000_3020, 32'h0,        0, 1);
        v("jr_hi",      0, 0, 3'd2, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'hA000_3000, 0, 0, 0, 32'h0000_3028, 32'h0,       0, 1);
        v("j",          0, 0, 3'd1, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h100,   32'h0,        0, 0, 0, 32'hA000_3000, 32'h0,        0, 1);
        v("jr",         0, 0, 3'd2, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0000_3040, 0, 0, 0, 32'hA000_0400, 32'h0,       0, 1);
        v("ill_op",     0, 0, 3'd5, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3040, 32'h0,        0, 1);
        v("ill_cnd",    0, 0, 3'd3, 3'd6, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3000, 32'h0,        0, 1);
        v("jr_3008",    0, 0, 3'd2, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0000_3008, 0, 0, 0, 32'h0000_3000, 32'h0,       0, 1);
        v("stl_irq",    0, 1, 3'd1, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h3FF,   32'h0,        1, 1, 0, 32'h0000_3008, 32'h0,        0, 0);
        v("stl_hold",   0, 1, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_3008, 32'h0,        0, 0);
        v("int_take",   0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_3008, 32'h0,        0, 1);
        v("hdl_seq",    0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_4180, 32'h0000_3008, 1, 0);
        v("nest_exc",   0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 1, 32'h0000_4184, 32'h0000_3008, 1, 1);
        v("irq_exl",    0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        1, 1, 0, 32'h0000_4180, 32'h0000_3008, 1, 0);
        v("eret",       0, 0, 3'd4, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_4184, 32'h0000_3008, 1, 1);
        v("ien_off",    0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 0, 0, 32'h0000_3008, 32'h0000_3008, 0, 0);
        v("ien_on",     0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_300C, 32'h0000_3008, 0, 1);
        v("eret2",      0, 0, 3'd4, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_4180, 32'h0000_300C, 1, 1);
        v("exc_stl",    0, 1, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 1, 32'h0000_300C, 32'h0000_300C, 0, 0);
        v("exc",        0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 1, 32'h0000_300C, 32'h0000_300C, 0, 1);
        v("hdl_seq2",   0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_4180, 32'h0000_300C, 1, 0);
        v("eret3",      0, 0, 3'd4, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_4184, 32'h0000_300C, 1, 1);
        v("irq_mask",   0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        1, 0, 0, 32'h0000_300C, 32'h0000_300C, 0, 0);
        v("set_wins",   0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        1, 1, 0, 32'h0000_3010, 32'h0000_300C, 0, 1);
        v("eret4",      0, 0, 3'd4, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_4180, 32'h0000_3010, 1, 1);
        v("int_again",  0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_3010, 32'h0000_3010, 0, 1);
        v("final",      0, 0, 3'd0, 3'd0, 32'h0,        32'h0, 16'h0000, 26'h0,     32'h0,        0, 1, 0, 32'h0000_4180, 32'h0000_3010, 1, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #4;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t required=finish before 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
